// File: rtl/traffic_lights_pkg.sv
// traffic_lights_pkg: command/mode encodings and request record shared by the controller and its issuer
package traffic_lights_pkg;
  localparam int DATA_W = 16;
  typedef enum logic [2:0] {
    CMD_ON         = 3'd0,
    CMD_OFF        = 3'd1,
    CMD_MANUAL     = 3'd2,
    CMD_SET_GREEN  = 3'd3,
    CMD_SET_RED    = 3'd4,
    CMD_SET_YELLOW = 3'd5
  } cmd_type_t;
  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_OFF    = 2'd1,
    MODE_MANUAL = 2'd2
  } mode_t;
  typedef struct packed {
    logic [2:0]        op;
    logic [DATA_W-1:0] data;
  } req_t;
  function automatic logic is_cfg(input logic [2:0] op);
    return op >= 3'd3 && op <= 3'd5;
  endfunction
endpackage

// File: rtl/traffic_lights_cmd_fifo.sv
// traffic_lights_cmd_fifo: request queue of {op, data} with registered full/empty flags
module traffic_lights_cmd_fifo
  import traffic_lights_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic push_i,
  input  logic pop_i,
  input  req_t wdata_i,
  output req_t rdata_o,
  output logic full_o,
  output logic empty_o,
  output logic empty_nxt_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, empty_q, push, pop;
  req_t          mem [DEPTH];
  assign push        = push_i & ~full_q;
  assign pop         = pop_i & ~empty_q;
  assign cnt_d       = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  assign rdata_o     = mem[rd_q];
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign empty_nxt_o = cnt_d == '0;
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      cnt_q   <= cnt_d;
      full_q  <= cnt_d == (AW+1)'(DEPTH);
      empty_q <= cnt_d == '0;
    end
  always_ff @(posedge clk_i)
    if (push) mem[wr_q] <= wdata_i;
endmodule

// File: rtl/traffic_lights_cmd_issuer.sv
// traffic_lights_cmd_issuer: queues host requests and issues controller commands, wrapping config bursts in manual-yellow
module traffic_lights_cmd_issuer
  import traffic_lights_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_op_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              cmd_valid_o,
  output logic [2:0]        cmd_type_o,
  output logic [DATA_W-1:0] cmd_data_o,
  output logic [1:0]        mode_o,
  output logic              busy_o,
  output logic              err_o
);
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_PRE, S_CFG, S_RESTORE, S_GAP} state_t;
  state_t            state_q, state_d, ret_q, ret_d, tgt, res, disp_st;
  logic [GW-1:0]     gap_q, gap_d;
  req_t              cur_q, cur_d, head;
  mode_t             mode_q, mode_d, rmode_q, rmode_d;
  logic              rvld_q, rvld_d, cmd_valid_q, cmd_valid_d, busy_q, err_q;
  logic [2:0]        cmd_type_q, cmd_type_d;
  logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
  logic              fifo_full, fifo_empty, empty_nxt;
  logic              accept, reject, emit, go, cfg_pop, dispatch;
  assign accept  = req_valid_i & ~fifo_full;
  assign reject  = (req_op_i > 3'd5) | (is_cfg(req_op_i) & (req_data_i == '0));
  assign emit    = state_q inside {S_ISSUE, S_PRE, S_CFG, S_RESTORE};
  assign cfg_pop = (state_q == S_CFG) & rvld_q & ~fifo_empty & is_cfg(head.op);
  // leaving GAP (or emitting with no gap) resolves the follow-on state this edge, so spacing stays exact
  assign go      = (state_q == S_IDLE) | ((state_q == S_GAP) & (gap_q == '0)) | (emit & (GAP_CYCLES == 0));
  traffic_lights_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .push_i      (accept & ~reject),
    .pop_i       (dispatch | cfg_pop),
    .wdata_i     (req_t'({req_op_i, req_data_i})),
    .rdata_o     (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .empty_nxt_o (empty_nxt)
  );
  always_comb begin
    cmd_valid_d = emit;
    cmd_type_d  = state_q == S_PRE ? CMD_MANUAL :
                  state_q == S_RESTORE ? (rmode_q == MODE_OFF ? CMD_OFF : CMD_ON) :
                  emit ? cur_q.op : 3'd0;
    cmd_data_d  = state_q == S_CFG ? cur_q.data : '0;
    mode_d      = (cmd_valid_d & (cmd_type_d < 3'd3)) ?
                  (cmd_type_d == 3'd0 ? MODE_NORMAL : cmd_type_d == 3'd1 ? MODE_OFF : MODE_MANUAL) : mode_q;
  end
  always_comb begin
    tgt      = state_q == S_PRE ? S_CFG :
               ((state_q == S_CFG) & rvld_q) ? (cfg_pop ? S_CFG : S_RESTORE) : S_IDLE;
    res      = state_q == S_GAP ? ret_q : tgt;
    disp_st  = is_cfg(head.op) ? (mode_d == MODE_MANUAL ? S_CFG : S_PRE) : S_ISSUE;
    dispatch = go & (res == S_IDLE) & ~fifo_empty;
    state_d  = dispatch ? disp_st : go ? res : emit ? S_GAP : state_q;
    ret_d    = emit ? tgt : ret_q;
    gap_d    = emit ? GW'(GAP_CYCLES - 1) : state_q == S_GAP ? gap_q - GW'(1) : gap_q;
    cur_d    = (dispatch | cfg_pop) ? head : cur_q;
    rvld_d   = state_q == S_PRE ? 1'b1 : state_q == S_RESTORE ? 1'b0 : rvld_q;
    rmode_d  = state_q == S_PRE ? mode_q : rmode_q;
  end
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      gap_q       <= '0;
      cur_q       <= '0;
      mode_q      <= MODE_NORMAL;
      rmode_q     <= MODE_NORMAL;
      rvld_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= '0;
      cmd_data_q  <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      gap_q       <= gap_d;
      cur_q       <= cur_d;
      mode_q      <= mode_d;
      rmode_q     <= rmode_d;
      rvld_q      <= rvld_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_data_q  <= cmd_data_d;
      busy_q      <= (state_d != S_IDLE) | ~empty_nxt;
      err_q       <= accept & reject;
    end
  assign req_ready_o = ~fifo_full;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_type_o  = cmd_type_q;
  assign cmd_data_o  = cmd_data_q;
  assign mode_o      = mode_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_traffic_lights_cmd_issuer.sv
// tb_traffic_lights_cmd_issuer: directed and random requests checked against a sequence-level command model
module tb_traffic_lights_cmd_issuer;
  logic        clk = 1'b0, arst_n = 1'b0, req_valid = 1'b0;
  logic [2:0]  req_op = '0;
  logic [15:0] req_data = '0;
  logic        req_ready, cmd_valid, busy, err;
  logic [2:0]  cmd_type;
  logic [15:0] cmd_data;
  logic [1:0]  mode;
  int total = 0, bad = 0, cyc = 0, mm = 0, n0;
  int pt[$], pd[$], pc[$], et[$], ed[$], ro[$], rd[$];

  traffic_lights_cmd_issuer #(.FIFO_DEPTH(4), .GAP_CYCLES(1)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_data_i(req_data), .cmd_valid_o(cmd_valid), .cmd_type_o(cmd_type),
    .cmd_data_o(cmd_data), .mode_o(mode), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (arst_n) begin
    if (cmd_valid) begin
      pt.push_back(int'(cmd_type));
      pd.push_back(int'(cmd_data));
      pc.push_back(cyc);
      if (cmd_type < 3'd3) chk("mode_follows_cmd", int'(mode), int'(cmd_type));
    end else chk("idle_outputs_zero", int'({cmd_type, cmd_data}), 0);
  end

  task automatic push(input int op, input int data);
    req_valid = 1'b1;
    req_op    = op[2:0];
    req_data  = data[15:0];
    for (int i = 0; i < 100; i++) begin
      if (req_ready) begin
        @(posedge clk); #1;
        req_valid = 1'b0;
        ro.push_back(op);
        rd.push_back(data);
        return;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("push_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && !cmd_valid) return;
    end
    chk("idle_timeout", 0, 1);
  endtask

  function automatic bit good_cfg(input int op, input int d);
    return op >= 3 && op <= 5 && d != 0;
  endfunction

  // expected command stream: plain ops pass through; a config run outside MANUAL is wrapped once
  task automatic build();
    int i = 0;
    et.delete(); ed.delete();
    while (i < ro.size()) begin
      if (ro[i] > 5 || (ro[i] >= 3 && rd[i] == 0)) i++;
      else if (ro[i] < 3) begin
        et.push_back(ro[i]); ed.push_back(0); mm = ro[i]; i++;
      end else if (mm == 2) begin
        et.push_back(ro[i]); ed.push_back(rd[i]); i++;
      end else begin
        int sv = mm;
        et.push_back(2); ed.push_back(0);
        while (i < ro.size() && good_cfg(ro[i], rd[i])) begin
          et.push_back(ro[i]); ed.push_back(rd[i]); i++;
        end
        et.push_back(sv == 0 ? 0 : 1); ed.push_back(0);
      end
    end
  endtask

  task automatic compare(input string tag);
    build();
    chk({tag, "_count"}, pt.size(), et.size());
    for (int i = 0; i < pt.size() && i < et.size(); i++) begin
      chk({tag, "_type"}, pt[i], et[i]);
      chk({tag, "_data"}, pd[i], ed[i]);
      if (i > 0) chk({tag, "_spacing"}, pc[i] - pc[i-1], 2);
    end
    chk({tag, "_mode"}, int'(mode), mm);
    chk({tag, "_busy"}, int'(busy), 0);
    pt.delete(); pd.delete(); pc.delete(); ro.delete(); rd.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_type", int'(cmd_type), 0);
    chk("rst_data", int'(cmd_data), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    arst_n = 1'b1;
    @(negedge clk);
    push(1, 0); n0 = cyc;
    wait_idle();
    chk("lat_off", pc.size() > 0 ? pc[0] : -1, n0 + 2);
    compare("off");
    push(0, 0); wait_idle(); compare("on");
    push(3, 100); n0 = cyc;
    wait_idle();
    chk("lat_wrap", pc.size() > 0 ? pc[0] : -1, n0 + 2);
    compare("wrap_normal");
    push(1, 0); wait_idle(); compare("off2");
    push(3, 100); push(4, 200); push(5, 300);
    wait_idle(); compare("burst_off");
    push(6, 0);
    chk("err_op6", int'(err), 1);
    @(posedge clk); #1;
    chk("err_op6_clear", int'(err), 0);
    repeat (4) @(negedge clk);
    compare("err_op6");
    push(4, 0);
    chk("err_zero", int'(err), 1);
    @(posedge clk); #1;
    chk("err_zero_clear", int'(err), 0);
    repeat (4) @(negedge clk);
    compare("err_zero");
    push(3, 5); push(0, 0); push(2, 0); push(1, 0); push(0, 0);
    chk("full_ready", int'(req_ready), 0);
    push(2, 0);
    wait_idle(); compare("stall");
    repeat (8) begin
      int len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        int op = $urandom_range(0, 5);
        push(op, op >= 3 ? $urandom_range(1, 65535) : 0);
      end
      wait_idle(); compare("random");
    end
    push(0, 0); wait_idle(); compare("pre_reset");
    push(3, 77);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_valid) break;
    end
    chk("mid_type2", int'(cmd_type), 2);
    arst_n = 1'b0;
    #1;
    chk("mid_valid", int'(cmd_valid), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_mode", int'(mode), 0);
    chk("mid_ready", int'(req_ready), 1);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    pt.delete(); pd.delete(); pc.delete(); ro.delete(); rd.delete();
    mm = 0;
    repeat (12) @(negedge clk);
    chk("mid_no_restore", pt.size(), 0);
    chk("mid_idle_busy", int'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
